// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg
//   Shared types and constants for the SPI frame sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   CS_SYNC_STAGES : flop depth of the chip-select synchronizer
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int CS_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_frame_sequencer_sync_2ff.sv
// sync_2ff
//   Single-bit multi-flop synchronizer with asynchronous active-low reset.
//   Used to bring the SPI chip-select into the system clock domain.
//   Ports:
//     clk   in   destination clock
//     rst_n in   asynchronous active-low reset
//     d     in   asynchronous input
//     q     out  synchronized output
//   RESET_VAL sets the value the chain holds in reset, so an idle-high
//   input does not produce a spurious edge when reset releases.
module sync_2ff
    import spi_seq_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [CS_SYNC_STAGES-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {CS_SYNC_STAGES{RESET_VAL}};
        end else begin
            stage <= {stage[CS_SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[CS_SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//   Collects words from the SPI word receiver into pixels and writes them to a
//   ping-pong frame buffer. A frame is one chip-select low window; frames that
//   end early or carry extra words are flagged on frame_err_out.
//
//   Optional feature macro: SPI_SEQ_CHECKSUM_EN adds checksum_out, the 16-bit
//   wrapping sum of all words written in the last completed frame.
//
//   Ports:
//     clk_in          in   system clock
//     rst_n_in        in   asynchronous active-low reset
//     word_in         in   received word, line 0 in the MSBs
//     word_valid_in   in   single-cycle strobe qualifying word_in
//     chip_sel_in     in   SPI chip-select, active low, asynchronous
//     wr_addr_out     out  BRAM write address within the current buffer
//     wr_data_out     out  assembled pixel
//     wr_en_out       out  BRAM write strobe
//     buf_sel_out     out  buffer being written; the display reads the other
//     frame_done_out  out  pulse, complete frame committed
//     frame_err_out   out  pulse, short or overlong frame
//     busy_out        out  high while receiving a frame
//     checksum_out    out  (SPI_SEQ_CHECKSUM_EN only) per-frame word sum
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for chip-select to fall; words ignored
//   RECV  | packing words into pixels and writing them out
//   DRAIN | frame complete, waiting for chip-select to rise
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int LINES           = 2,
    parameter int WORDS_PER_PIXEL = 1,
    parameter int H_PIXELS        = 320,
    parameter int V_PIXELS        = 180,
    localparam int FRAME_PIXELS   = H_PIXELS * V_PIXELS,
    localparam int WORD_W         = LINES * DATA_WIDTH,
    localparam int PIX_W          = WORDS_PER_PIXEL * WORD_W,
    localparam int ADDR_W         = $clog2(FRAME_PIXELS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid_in,
    input  logic              chip_sel_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [PIX_W-1:0]  wr_data_out,
    output logic              wr_en_out,
    output logic              buf_sel_out,
    output logic              frame_done_out,
    output logic              frame_err_out,
    output logic              busy_out
`ifdef SPI_SEQ_CHECKSUM_EN
    ,
    output logic [15:0]       checksum_out
`endif
);

    localparam int WC_W = (WORDS_PER_PIXEL > 1) ? $clog2(WORDS_PER_PIXEL) : 1;

    logic cs_sync;
    logic cs_prev;
    logic cs_fall;
    logic cs_rise;

    seq_state_t state_q;
    seq_state_t state_d;

    logic [WC_W-1:0]   word_cnt;
    logic [ADDR_W-1:0] pix_cnt;
    logic [PIX_W-1:0]  pixel_q;
    logic [PIX_W-1:0]  pix_next;
    logic              done_pend;
    logic              drain_err_seen;

    logic word_rx;
    logic pixel_done;
    logic frame_last;
    logic start_frame;
    logic err_short;
    logic err_drain;

    // Idle CS is high, so the synchronizer and edge register reset high to
    // avoid a false edge at reset release.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .d     (chip_sel_in),
        .q     (cs_sync)
    );

    assign cs_fall = cs_prev & ~cs_sync;
    assign cs_rise = ~cs_prev & cs_sync;

    // First word lands in the MSBs; for a single-word pixel the shift
    // clears the (always zero) register entirely.
    assign pix_next = (pixel_q << WORD_W) | PIX_W'(word_in);

    assign busy_out = (state_q == RECV);

    always_comb begin
        word_rx     = (state_q == RECV) && word_valid_in;
        pixel_done  = word_rx && (word_cnt == WC_W'(WORDS_PER_PIXEL - 1));
        frame_last  = pixel_done && (pix_cnt == ADDR_W'(FRAME_PIXELS - 1));
        start_frame = (state_q == IDLE) && cs_fall;
        // The word in a CS-rise cycle is handled first, so a rise that
        // coincides with the final word is a completed frame, not an error.
        err_short   = (state_q == RECV) && cs_rise && !frame_last;
        err_drain   = (state_q == DRAIN) && word_valid_in && !drain_err_seen;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (frame_last) begin
                    // CS already back high: nothing left to drain.
                    state_d = cs_rise ? IDLE : DRAIN;
                end else if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cs_prev        <= 1'b1;
            word_cnt       <= '0;
            pix_cnt        <= '0;
            pixel_q        <= '0;
            done_pend      <= 1'b0;
            drain_err_seen <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            wr_en_out      <= 1'b0;
            buf_sel_out    <= 1'b0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            cs_prev        <= cs_sync;
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
            done_pend      <= 1'b0;

            if (start_frame) begin
                word_cnt       <= '0;
                pix_cnt        <= '0;
                pixel_q        <= '0;
                drain_err_seen <= 1'b0;
            end

            if (word_rx) begin
                if (pixel_done) begin
                    wr_en_out   <= 1'b1;
                    wr_data_out <= pix_next;
                    wr_addr_out <= pix_cnt;
                    word_cnt    <= '0;
                    pixel_q     <= '0;
                    if (frame_last) begin
                        pix_cnt   <= '0;
                        done_pend <= 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + ADDR_W'(1);
                    end
                end else begin
                    pixel_q  <= pix_next;
                    word_cnt <= word_cnt + WC_W'(1);
                end
            end

            if (err_short) begin
                frame_err_out <= 1'b1;
                pixel_q       <= '0;
                word_cnt      <= '0;
            end

            if (err_drain) begin
                frame_err_out  <= 1'b1;
                drain_err_seen <= 1'b1;
            end

            // Done and the buffer swap land one cycle after the last write.
            if (done_pend) begin
                frame_done_out <= 1'b1;
                buf_sel_out    <= ~buf_sel_out;
            end
        end
    end

`ifdef SPI_SEQ_CHECKSUM_EN
    logic [15:0] csum_acc;
    logic [15:0] csum_pix;

    // Words of a pixel are held aside until that pixel is written, so a
    // discarded partial pixel never reaches the frame sum.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            csum_acc     <= '0;
            csum_pix     <= '0;
            checksum_out <= '0;
        end else begin
            if (start_frame) begin
                csum_acc <= '0;
                csum_pix <= '0;
            end
            if (word_rx) begin
                if (pixel_done) begin
                    csum_acc <= csum_acc + csum_pix + 16'(word_in);
                    csum_pix <= '0;
                end else begin
                    csum_pix <= csum_pix + 16'(word_in);
                end
            end
            if (err_short) begin
                csum_pix <= '0;
            end
            if (done_pend) begin
                checksum_out <= csum_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_frame_sequencer.sv
module tb_spi_frame_sequencer;

    logic clk;
    logic rst_n;

    logic [15:0] word1;
    logic        valid1;
    logic        cs1;
    logic [2:0]  addr1;
    logic [15:0] data1;
    logic        wr_en1, buf1, done1, err1, busy1;

    logic [15:0] word2;
    logic        valid2;
    logic        cs2;
    logic [2:0]  addr2;
    logic [31:0] data2;
    logic        wr_en2, buf2, done2, err2, busy2;

`ifdef SPI_SEQ_CHECKSUM_EN
    logic [15:0] csum1;
    logic [15:0] csum2;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] exp1_q[$];
    logic [63:0] obs1_q[$];
    logic [63:0] exp2_q[$];
    logic [63:0] obs2_q[$];

    int done_cnt1 = 0;
    int err_cnt1  = 0;
    int done_cnt2 = 0;
    int err_cnt2  = 0;

    spi_frame_sequencer #(
        .DATA_WIDTH      (8),
        .LINES           (2),
        .WORDS_PER_PIXEL (1),
        .H_PIXELS        (4),
        .V_PIXELS        (2)
    ) dut1 (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .word_in        (word1),
        .word_valid_in  (valid1),
        .chip_sel_in    (cs1),
        .wr_addr_out    (addr1),
        .wr_data_out    (data1),
        .wr_en_out      (wr_en1),
        .buf_sel_out    (buf1),
        .frame_done_out (done1),
        .frame_err_out  (err1),
        .busy_out       (busy1)
`ifdef SPI_SEQ_CHECKSUM_EN
        ,
        .checksum_out   (csum1)
`endif
    );

    spi_frame_sequencer #(
        .DATA_WIDTH      (8),
        .LINES           (2),
        .WORDS_PER_PIXEL (2),
        .H_PIXELS        (4),
        .V_PIXELS        (2)
    ) dut2 (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .word_in        (word2),
        .word_valid_in  (valid2),
        .chip_sel_in    (cs2),
        .wr_addr_out    (addr2),
        .wr_data_out    (data2),
        .wr_en_out      (wr_en2),
        .buf_sel_out    (buf2),
        .frame_done_out (done2),
        .frame_err_out  (err2),
        .busy_out       (busy2)
`ifdef SPI_SEQ_CHECKSUM_EN
        ,
        .checksum_out   (csum2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en1) obs1_q.push_back({32'(addr1), 32'(data1)});
        if (done1)  done_cnt1++;
        if (err1)   err_cnt1++;
        if (wr_en2) obs2_q.push_back({32'(addr2), data2});
        if (done2)  done_cnt2++;
        if (err2)   err_cnt2++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_start1();
        cs1 = 1'b0;
        tick(4);
    endtask

    task automatic frame_end1();
        cs1 = 1'b1;
        tick(6);
    endtask

    task automatic send1(input logic [15:0] w, input bit wr, input int addr);
        if (wr) exp1_q.push_back({32'(addr), 32'(w)});
        word1  = w;
        valid1 = 1'b1;
        tick(1);
        valid1 = 1'b0;
    endtask

    task automatic send2(input logic [15:0] w);
        word2  = w;
        valid2 = 1'b1;
        tick(1);
        valid2 = 1'b0;
    endtask

    task automatic check_writes1(input string tag);
        check({tag, "_nwr"}, 64'(obs1_q.size()), 64'(exp1_q.size()));
        while (exp1_q.size() > 0 && obs1_q.size() > 0)
            check({tag, "_wr"}, obs1_q.pop_front(), exp1_q.pop_front());
        exp1_q.delete();
        obs1_q.delete();
    endtask

    task automatic check_writes2(input string tag);
        check({tag, "_nwr"}, 64'(obs2_q.size()), 64'(exp2_q.size()));
        while (exp2_q.size() > 0 && obs2_q.size() > 0)
            check({tag, "_wr"}, obs2_q.pop_front(), exp2_q.pop_front());
        exp2_q.delete();
        obs2_q.delete();
    endtask

    initial begin
        int d0;
        int e0;

        rst_n  = 1'b0;
        cs1    = 1'b1;
        cs2    = 1'b1;
        valid1 = 1'b0;
        valid2 = 1'b0;
        word1  = '0;
        word2  = '0;
        tick(3);

        // reset state
        check("rst_wr_en", 64'(wr_en1), 64'd0);
        check("rst_done",  64'(done1),  64'd0);
        check("rst_err",   64'(err1),   64'd0);
        check("rst_buf",   64'(buf1),   64'd0);
        check("rst_busy",  64'(busy1),  64'd0);
        check("rst_addr",  64'(addr1),  64'd0);
        check("rst_data",  64'(data1),  64'd0);
        rst_n = 1'b1;
        tick(3);

        // 1: full 8-pixel frame
        d0 = done_cnt1; e0 = err_cnt1;
        frame_start1();
        check("t1_busy", 64'(busy1), 64'd1);
        for (int i = 0; i < 8; i++) send1(16'h0100 + 16'(i), 1'b1, i);
        tick(3);
        check("t1_done", 64'(done_cnt1 - d0), 64'd1);
        check("t1_err",  64'(err_cnt1 - e0),  64'd0);
        check("t1_buf",  64'(buf1), 64'd1);
        frame_end1();
        check("t1_busy_end", 64'(busy1), 64'd0);
        check_writes1("t1");

        // 2: two words per pixel, MSB word first
        d0 = done_cnt2; e0 = err_cnt2;
        cs2 = 1'b0;
        tick(4);
        exp2_q.push_back({32'd0, 32'hAAAA5555});
        send2(16'hAAAA);
        send2(16'h5555);
        tick(3);
        cs2 = 1'b1;
        tick(6);
        check_writes2("t2");
        check("t2_done", 64'(done_cnt2 - d0), 64'd0);
        check("t2_err",  64'(err_cnt2 - e0),  64'd1);
        check("t2_buf",  64'(buf2),  64'd0);
        check("t2_busy", 64'(busy2), 64'd0);

        // 3: short frame, then a full frame restarting at address 0
        d0 = done_cnt1; e0 = err_cnt1;
        frame_start1();
        for (int i = 0; i < 5; i++) send1(16'h0200 + 16'(i), 1'b1, i);
        tick(2);
        frame_end1();
        check("t3_err",  64'(err_cnt1 - e0),  64'd1);
        check("t3_done", 64'(done_cnt1 - d0), 64'd0);
        check("t3_buf",  64'(buf1), 64'd1);
        check_writes1("t3_short");
        d0 = done_cnt1; e0 = err_cnt1;
        frame_start1();
        for (int i = 0; i < 8; i++) send1(16'h0300 + 16'(i), 1'b1, i);
        tick(3);
        frame_end1();
        check("t3_done2", 64'(done_cnt1 - d0), 64'd1);
        check("t3_err2",  64'(err_cnt1 - e0),  64'd0);
        check("t3_buf2",  64'(buf1), 64'd0);
        check_writes1("t3_full");

        // 4: overlong frame
        d0 = done_cnt1; e0 = err_cnt1;
        frame_start1();
        for (int i = 0; i < 10; i++) send1(16'h0400 + 16'(i), i < 8, i);
        tick(3);
        frame_end1();
        check("t4_done", 64'(done_cnt1 - d0), 64'd1);
        check("t4_err",  64'(err_cnt1 - e0),  64'd1);
        check("t4_buf",  64'(buf1), 64'd1);
        check_writes1("t4");

        // 5: reset mid-frame
        frame_start1();
        for (int i = 0; i < 3; i++) send1(16'h0500 + 16'(i), 1'b1, i);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("t5_wr_en", 64'(wr_en1), 64'd0);
        check("t5_buf",   64'(buf1),   64'd0);
        check("t5_busy",  64'(busy1),  64'd0);
        check("t5_addr",  64'(addr1),  64'd0);
        check("t5_data",  64'(data1),  64'd0);
        check("t5_done",  64'(done1),  64'd0);
        check("t5_err",   64'(err1),   64'd0);
        cs1 = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check_writes1("t5_pre");
        d0 = done_cnt1;
        frame_start1();
        for (int i = 0; i < 8; i++) send1(16'h0600 + 16'(i), 1'b1, i);
        tick(3);
        frame_end1();
        check("t5_done2", 64'(done_cnt1 - d0), 64'd1);
        check("t5_buf2",  64'(buf1), 64'd1);
        check_writes1("t5_post");

        // 6: final word coincides with the synchronized CS rise
        d0 = done_cnt1; e0 = err_cnt1;
        frame_start1();
        for (int i = 0; i < 5; i++) send1(16'h0100 + 16'(i), 1'b1, i);
        cs1 = 1'b1;
        for (int i = 5; i < 8; i++) send1(16'h0100 + 16'(i), 1'b1, i);
        tick(8);
        check("t6_done", 64'(done_cnt1 - d0), 64'd1);
        check("t6_err",  64'(err_cnt1 - e0),  64'd0);
        check("t6_busy", 64'(busy1), 64'd0);
        check("t6_buf",  64'(buf1),  64'd0);
        check_writes1("t6");
`ifdef SPI_SEQ_CHECKSUM_EN
        check("t6_csum", 64'(csum1), 64'h081C);
`endif
        // sequencer must be back in IDLE, ready for a new frame
        e0 = err_cnt1;
        frame_start1();
        send1(16'h0700, 1'b1, 0);
        send1(16'h0701, 1'b1, 1);
        tick(2);
        frame_end1();
        check("t6_next_err", 64'(err_cnt1 - e0), 64'd1);
        check_writes1("t6_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
